// File: rtl/simon_round_controller.sv
// Simon Says round sequencer: plays a growing prefix of a latched 4-step pattern,
// then checks the player's presses against it and reports win or lose.
module simon_round_controller #(
  parameter int unsigned STEP_CYCLES    = 8,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] sequence_word,
  input  logic       btn_valid,
  input  logic [1:0] btn_dir,
  output logic [1:0] arrow_dir,
  output logic       arrow_valid,
  output logic       expect_input,
  output logic [2:0] round,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int unsigned MAX_A = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SHOW_ON, SHOW_GAP, WAIT_INPUT, WIN, LOSE
  } state_t;

  state_t           state;
  logic [7:0]       seq_q;
  logic [1:0]       step_idx;
  logic [CNT_W-1:0] cyc_cnt;
  logic             lead_q;

  // `sequence` is a reserved word, hence the sequence_word port name.
  function automatic logic [1:0] step_of(input logic [7:0] s, input logic [1:0] k);
    case (k)
      2'd0:    step_of = s[7:6];
      2'd1:    step_of = s[5:4];
      2'd2:    step_of = s[3:2];
      default: step_of = s[1:0];
    endcase
  endfunction

  // {arrow_valid, expect_input, busy, win, lose} for the state being entered
  function automatic logic [4:0] flags_for(input state_t s);
    case (s)
      SHOW_ON:    flags_for = 5'b10100;
      SHOW_GAP:   flags_for = 5'b00100;
      WAIT_INPUT: flags_for = 5'b01100;
      WIN:        flags_for = 5'b00010;
      LOSE:       flags_for = 5'b00001;
      default:    flags_for = 5'b00000;
    endcase
  endfunction

  logic [1:0] last_step;
  assign last_step = 2'(round - 3'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      seq_q    <= '0;
      step_idx <= '0;
      cyc_cnt  <= '0;
      lead_q   <= 1'b0;
      round    <= '0;
      arrow_dir <= '0;
      {arrow_valid, expect_input, busy, win, lose} <= '0;
    end else begin
      case (state)
        IDLE, WIN, LOSE: begin
          if (start) begin
            state     <= SHOW_ON;
            seq_q     <= sequence_word;
            round     <= 3'd1;
            step_idx  <= '0;
            cyc_cnt   <= '0;
            lead_q    <= 1'b0;
            arrow_dir <= step_of(sequence_word, 2'd0);
            {arrow_valid, expect_input, busy, win, lose} <= flags_for(SHOW_ON);
          end
        end

        SHOW_ON: begin
          if (cyc_cnt == STEP_LAST) begin
            state   <= SHOW_GAP;
            cyc_cnt <= '0;
            {arrow_valid, expect_input, busy, win, lose} <= flags_for(SHOW_GAP);
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        SHOW_GAP: begin
          if (cyc_cnt == GAP_LAST) begin
            cyc_cnt <= '0;
            // A lead gap precedes step 0 of a new round; otherwise a gap trails step_idx.
            if (lead_q) begin
              lead_q    <= 1'b0;
              state     <= SHOW_ON;
              arrow_dir <= step_of(seq_q, 2'd0);
              {arrow_valid, expect_input, busy, win, lose} <= flags_for(SHOW_ON);
            end else if (step_idx == last_step) begin
              state    <= WAIT_INPUT;
              step_idx <= '0;
              {arrow_valid, expect_input, busy, win, lose} <= flags_for(WAIT_INPUT);
            end else begin
              state     <= SHOW_ON;
              step_idx  <= step_idx + 1'b1;
              arrow_dir <= step_of(seq_q, step_idx + 1'b1);
              {arrow_valid, expect_input, busy, win, lose} <= flags_for(SHOW_ON);
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        WAIT_INPUT: begin
          if (btn_valid) begin
            cyc_cnt <= '0;
            if (btn_dir != step_of(seq_q, step_idx)) begin
              state <= LOSE;
              {arrow_valid, expect_input, busy, win, lose} <= flags_for(LOSE);
            end else if (step_idx != last_step) begin
              step_idx <= step_idx + 1'b1;
            end else if (round == 3'd4) begin
              state <= WIN;
              {arrow_valid, expect_input, busy, win, lose} <= flags_for(WIN);
            end else begin
              state    <= SHOW_GAP;
              round    <= round + 3'd1;
              step_idx <= '0;
              lead_q   <= 1'b1;
              {arrow_valid, expect_input, busy, win, lose} <= flags_for(SHOW_GAP);
            end
          end else if (cyc_cnt == TO_LAST) begin
            state   <= LOSE;
            cyc_cnt <= '0;
            {arrow_valid, expect_input, busy, win, lose} <= flags_for(LOSE);
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          {arrow_valid, expect_input, busy, win, lose} <= flags_for(IDLE);
        end
      endcase
    end
  end

endmodule

// File: doc/simon_round_controller.md
# simon_round_controller

Round sequencer for the Simon Says game. It latches an 8-bit, four-direction pattern and plays a growing prefix of it on the arrow display, one round at a time. Between playbacks it checks the player's button presses against the same prefix and reports a win or a loss. It sits between the pattern source and the display/button logic, and replaces free-running playback with a controlled show/listen loop.

## Interface
Parameters:
- STEP_CYCLES, 8: cycles each arrow is shown (arrow_valid high); must be ≥ 1.
- GAP_CYCLES, 4: blank cycles after each arrow, and before the first arrow of rounds 2–4; must be ≥ 1.
- TIMEOUT_CYCLES, 64: cycles allowed per expected press before a loss; must be ≥ 2.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE, WIN or LOSE.
- sequence  in  8  pattern; step 0 = [7:6], step 1 = [5:4], step 2 = [3:2], step 3 = [1:0]; latched on accepted start.
- btn_valid  in  1  one-cycle pulse per press (already debounced upstream).
- btn_dir  in  2  direction of the press; valid when btn_valid is high.
- arrow_dir  out  2  direction being shown.
- arrow_valid  out  1  high only in SHOW_ON.
- expect_input  out  1  high only in WAIT_INPUT.
- round  out  3  current round, 1..4; 0 in IDLE.
- busy  out  1  high in SHOW_ON, SHOW_GAP and WAIT_INPUT.
- win  out  1  high only in WIN.
- lose  out  1  high only in LOSE.

## Operation
- All outputs are registered. On reset, every output is 0, the state is IDLE and all counters are 0.
- States are IDLE, SHOW_ON, SHOW_GAP, WAIT_INPUT, WIN and LOSE.
- Internal registers:
  - seq_q, 8 bits.
  - step_idx, 2 bits.
  - round, 3 bits.
  - cyc_cnt, wide enough for max(STEP_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES).
- Transitions:
  - IDLE, WIN or LOSE with start=1 → SHOW_ON. Latch sequence into seq_q; set round=1, step_idx=0, arrow_dir=seq_q step 0. win and lose clear.
  - SHOW_ON → SHOW_GAP after exactly STEP_CYCLES cycles. arrow_dir holds its value during the gap.
  - SHOW_GAP → SHOW_ON after GAP_CYCLES cycles, if steps remain in this round. step_idx increments and arrow_dir takes the next step.
  - SHOW_GAP → WAIT_INPUT after GAP_CYCLES cycles, once step round−1 has been shown. step_idx resets to 0.
  - WAIT_INPUT, btn_valid with btn_dir equal to step step_idx, and this is not the last step of the round: step_idx increments and the timeout counter restarts.
  - WAIT_INPUT, correct press on the last step, round < 4 → SHOW_GAP as a lead gap. round increments and step_idx=0; after the gap, SHOW_ON shows step 0.
  - WAIT_INPUT, correct press on the last step, round = 4 → WIN.
  - WAIT_INPUT, btn_valid with a mismatching btn_dir → LOSE.
  - WAIT_INPUT, TIMEOUT_CYCLES cycles with no press → LOSE.
- WIN and LOSE hold until start. round keeps its last value in these states.
- start is ignored in SHOW_ON, SHOW_GAP and WAIT_INPUT.
- btn_valid is ignored outside WAIT_INPUT.
- sequence changes after latch have no effect until the next accepted start.

## Timing
- start accepted at edge E: SHOW_ON is visible from edge E+1.
- Round r playback occupies r·(STEP_CYCLES+GAP_CYCLES) cycles, plus a GAP_CYCLES lead gap for r ≥ 2.
- Press latency: a btn_valid sampled at edge E gives its result (step advance, next state, win or lose) at edge E+1.
- Timeout: if a WAIT_INPUT cycle sees no btn_valid and it is the TIMEOUT_CYCLES-th such cycle since entry or since the last accepted press, lose=1 on the next edge.
- A btn_valid in the same cycle the timeout would expire takes priority; the timeout does not fire.
- reset_n low at any time, including mid-playback or mid-input, forces IDLE with all outputs 0 immediately, without waiting for a clock edge.
- On release, the block stays in IDLE until start is seen on a rising edge.

## Test plan
- Default parameters, sequence=8'b00_01_10_11, start at cycle 0:
  - Cycles 1–8: arrow_valid=1, arrow_dir=0.
  - Cycles 9–12: gap.
  - Cycle 13: expect_input=1.
  - Press 0: next cycle SHOW_GAP with round=2, then arrow 0 is shown, then arrow 1.
- Same sequence, all presses correct through round 4 (10 presses in total): win=1 one cycle after the final press of 3, busy=0, round=4.
- Round 2, first press correct, second press btn_dir=2 (expected 1): lose=1 next cycle; win=0, expect_input=0.
- WAIT_INPUT entered, no press: lose=1 exactly 64 cycles later. A second run presses correctly at the 64th cycle and advances with no lose.
- Reset:
  - Assert reset_n=0 during SHOW_ON of round 3: all outputs are 0 at once, with no clock edge needed.
  - After release, a start with a new sequence restarts at round 1 using the new pattern.
- Ignored inputs:
  - btn_valid pulses during playback do not change step_idx or the outcome.
  - start pulses during WAIT_INPUT have no effect.
  - start in LOSE restarts cleanly: lose clears and round=1.
